keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Front-end transmitter for the microwave controller's keypad/button interface.
- Scans a physical 4x3 matrix keypad and debounces key presses.
- Produces the one-hot `keypad[9:0]` vector plus active-low `startn`/`clearn` strobes consumed by `microwave`.
- Sits between board pins and the `microwave` core, on the same clock.

Parameters:
- SCAN_DIV, 1, clock cycles each column stays driven (dwell); must be >= 1.
- DEB_FRAMES, 2, consecutive identical scan frames required to accept a press or a release; must be >= 1.

Ports:
- clock  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rows_n  in  4  matrix row sense, pulled up externally; low = key closed in the active column.
- cols_n  out  3  column drive; exactly one bit low at any time.
- keypad  out  10  one-hot digit 0..9; bit d high while digit d is accepted.
- startn  out  1  low while '#' is accepted.
- clearn  out  1  low while '*' is accepted.
- key_valid  out  1  high while any key is accepted.

Behaviour:
- Reset (async, resetn=0): cols_n=3'b110, column index 0, dwell counter 0, debounce state IDLE, keypad=0, startn=1, clearn=1, key_valid=0.
- Key map (row, col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- Scan:
  - Column index advances 0->1->2->0 every SCAN_DIV cycles.
  - cols_n is a registered decode of the index: 110, 101, 011.
  - On the last dwell cycle of each column, rows_n is captured with no synchronizer. Row settling within one clock is a board requirement.
  - Wrap from column 2 to column 0 closes a frame of 3*SCAN_DIV cycles.
- Frame code, evaluated at frame close:
  - NONE if no row was low in any column.
  - KEY(k), k in 0..11, if exactly one closure was seen in the frame.
  - MULTI if two or more closures were seen.
- Debounce FSM (one update per frame):
  - IDLE: KEY(k) -> CAND with cand=k, cnt=1. NONE/MULTI -> IDLE.
  - CAND: KEY(cand) -> cnt+1; when cnt reaches DEB_FRAMES -> PRESSED. Any other code -> IDLE, cnt=0.
  - PRESSED: NONE -> REL with cnt=1. KEY(cand) or MULTI -> stay PRESSED; a held key is not dropped by a second key.
  - REL: NONE -> cnt+1; when cnt reaches DEB_FRAMES -> IDLE. KEY(cand) -> PRESSED. KEY(other) or MULTI -> PRESSED; the new key is not accepted until release completes.
- Outputs (registered, updated one cycle after the FSM state changes):
  - keypad[d] = 1 for digit d while in PRESSED or REL.
  - startn = 0 for '#', clearn = 0 for '*'; keypad stays 0 for these two keys.
  - key_valid = 1 in PRESSED or REL.
  - At most one of keypad/startn/clearn is active at a time.
- Latency with defaults (frame = 3 cycles):
  - Press to assertion: <= 3*(DEB_FRAMES+1)+1 = 10 cycles.
  - Release to deassertion: <= 10 cycles.
- Reset mid-press: outputs return to reset values immediately. After reset release the key is re-detected through the full debounce.

Optional Feature:
- Macro KEY_ONESHOT_EN.
- Defined:
  - keypad bit, startn low, or clearn low is a single-cycle pulse on the CAND->PRESSED transition only.
  - key_valid still follows PRESSED/REL as a level.
  - The next pulse requires a full release (REL->IDLE) first.
- Undefined: level behaviour as above.

Test Plan:
1. Reset asserted, then released; rows_n=4'b1111 -> outputs at reset values; cols_n cycles 110, 101, 011, 110 on consecutive clocks; keypad=0 for 20 cycles.
2. Hold '3' (rows_n[0]=0 while cols_n=011) for 11 cycles -> keypad=10'b0000001000 within 10 cycles of press, held stable; back to 0 within 10 cycles of release; key_valid tracks it.
3. Bounce: '5' closed 2 cycles, open 2, closed 2, then released -> keypad stays 0 and key_valid stays 0 throughout.
4. '1' and '9' held together for 12 cycles, then only '9' held for 12 cycles -> no output during the two-key period; keypad=10'b1000000000 after '9' alone is debounced.
5. '#' held 11 cycles, release, then '*' held 11 cycles -> startn low only during '#', clearn low only during '*'; keypad=0 and both strobes never low together.
6. Hold '7' until keypad[7]=1, pulse resetn low for 1 cycle -> keypad clears asynchronously; keypad[7] reasserts <= 10 cycles after reset release. With KEY_ONESHOT_EN defined, the same press produces exactly one 1-cycle keypad[7] pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with frame-based debounce, driving one-hot digits and '#'/'*' strobes.
// Optional KEY_ONESHOT_EN: key outputs become a single-cycle pulse per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV   = 1,
  parameter int unsigned DEB_FRAMES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] rows_n,
  output logic [2:0] cols_n,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       clearn,
  output logic       key_valid
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N      = CW'(DEB_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED, S_REL} state_t;
  typedef enum logic [1:0] {CODE_NONE, CODE_KEY, CODE_MULTI} code_t;

  logic [1:0]    col_idx, col_nxt;
  logic [DW-1:0] dwell;
  logic          last_dwell, frame_end;
  logic [1:0]    acc_cnt, tot_sat, row_sel;
  logic [3:0]    acc_key, key_sel;
  logic [2:0]    hits, tot;
  code_t         code;

  state_t        state, state_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

  logic [9:0]    keypad_d;
  logic          startn_d, clearn_d, valid_d, strobe;

  function automatic logic [2:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  assign last_dwell = (dwell == DWELL_LAST);
  assign col_nxt    = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
  assign frame_end  = last_dwell && (col_idx == 2'd2);

  // Merge this column's row closures into the running frame tally (count saturates at 2).
  always_comb begin
    hits    = '0;
    row_sel = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) begin
        hits    = hits + 3'd1;
        row_sel = 2'(i);
      end
    end
    tot     = 3'(acc_cnt) + hits;
    tot_sat = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    key_sel = (acc_cnt == 2'd0 && hits != 3'd0) ? (4'(row_sel) * 4'd3 + 4'(col_idx)) : acc_key;
    if (tot == 3'd0)      code = CODE_NONE;
    else if (tot == 3'd1) code = CODE_KEY;
    else                  code = CODE_MULTI;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_idx <= 2'd0;
      dwell   <= '0;
      cols_n  <= 3'b110;
      acc_cnt <= 2'd0;
      acc_key <= 4'd0;
    end else if (last_dwell) begin
      dwell   <= '0;
      col_idx <= col_nxt;
      cols_n  <= col_drive(col_nxt);
      acc_cnt <= (col_idx == 2'd2) ? 2'd0 : tot_sat;
      acc_key <= (col_idx == 2'd2) ? 4'd0 : key_sel;
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce: one decision per closed frame.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + CW'(1);
    if (frame_end) begin
      case (state)
        S_IDLE: if (code == CODE_KEY) begin
          cand_nxt  = key_sel;
          cnt_nxt   = CW'(1);
          state_nxt = (DEB_FRAMES <= 1) ? S_PRESSED : S_CAND;
        end
        S_CAND: if (code == CODE_KEY && key_sel == cand) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= DEB_N) state_nxt = S_PRESSED;
        end else begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
        S_PRESSED: if (code == CODE_NONE) begin
          cnt_nxt   = CW'(1);
          state_nxt = (DEB_FRAMES <= 1) ? S_IDLE : S_REL;
        end
        default: if (code == CODE_NONE) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= DEB_N) state_nxt = S_IDLE;
        end else begin
          state_nxt = S_PRESSED;
        end
      endcase
    end
  end

`ifdef KEY_ONESHOT_EN
  logic press_evt;

  // Marks the cycle the FSM has just accepted a new press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) press_evt <= 1'b0;
    else         press_evt <= frame_end && (state == S_IDLE || state == S_CAND) && (state_nxt == S_PRESSED);
  end
  assign strobe = press_evt;
`else
  assign strobe = valid_d;
`endif

  always_comb begin
    keypad_d = '0;
    startn_d = 1'b1;
    clearn_d = 1'b1;
    valid_d  = (state == S_PRESSED) || (state == S_REL);
    if (strobe) begin
      if (cand == 4'd9)       clearn_d = 1'b0;
      else if (cand == 4'd11) startn_d = 1'b0;
      else if (cand == 4'd10) keypad_d = 10'd1;
      else                    keypad_d = 10'd1 << (cand + 4'd1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      keypad    <= '0;
      startn    <= 1'b1;
      clearn    <= 1'b1;
      key_valid <= 1'b0;
    end else begin
      keypad    <= keypad_d;
      startn    <= startn_d;
      clearn    <= clearn_d;
      key_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix board model, directed plan steps and random key traffic
// compared cycle by cycle with a scan/debounce reference model.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV   = 1;
  localparam int unsigned DEB_FRAMES = 2;
`ifdef KEY_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif
  localparam int M_IDLE = 0, M_CAND = 1, M_PRESSED = 2, M_REL = 3;

  logic       clock, resetn;
  logic [3:0] rows_n;
  logic [2:0] cols_n;
  logic [9:0] keypad;
  logic       startn, clearn, key_valid;
  logic [11:0] pressed;

  int checks = 0;
  int errors = 0;

  string keymap = "123456789*0#";
  int    cyc, m_st, m_cand, m_cnt;
  bit    m_evt;
  int    seen[$];
  logic [2:0] e_cols;
  logic [9:0] e_keypad;
  logic       e_startn, e_clearn, e_valid;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) dut (
    .clock(clock), .resetn(resetn), .rows_n(rows_n), .cols_n(cols_n),
    .keypad(keypad), .startn(startn), .clearn(clearn), .key_valid(key_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Board: key k = row*3+col shorts row to the column currently driven low.
  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!cols_n[c] && pressed[r*3+c]) rows_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_st = M_IDLE; m_cand = 0; m_cnt = 0; m_evt = 1'b0;
    seen.delete();
    e_cols = 3'b110; e_keypad = '0; e_startn = 1'b1; e_clearn = 1'b1; e_valid = 1'b0;
  endtask

  // Effect of one rising edge with the current key set.
  task automatic model_step();
    int col, n, k;
    bit strobe, new_evt;
    byte ch;
    col     = (cyc / SCAN_DIV) % 3;
    e_valid = (m_st == M_PRESSED) || (m_st == M_REL);
    strobe  = ONESHOT ? m_evt : e_valid;
    e_keypad = '0; e_startn = 1'b1; e_clearn = 1'b1;
    if (strobe) begin
      ch = keymap[m_cand];
      if (ch == "#")      e_startn = 1'b0;
      else if (ch == "*") e_clearn = 1'b0;
      else                e_keypad = 10'(1) << (ch - "0");
    end
    new_evt = 1'b0;
    if ((cyc % SCAN_DIV) == SCAN_DIV - 1) begin
      for (int r = 0; r < 4; r++) if (pressed[r*3+col]) seen.push_back(r*3+col);
      if (col == 2) begin
        n = seen.size();
        k = (n == 1) ? seen[0] : -1;
        case (m_st)
          M_IDLE: if (n == 1) begin
            m_cand = k; m_cnt = 1;
            if (m_cnt >= DEB_FRAMES) begin m_st = M_PRESSED; new_evt = 1'b1; end
            else m_st = M_CAND;
          end
          M_CAND: if (k == m_cand) begin
            m_cnt++;
            if (m_cnt >= DEB_FRAMES) begin m_st = M_PRESSED; new_evt = 1'b1; end
          end else begin
            m_st = M_IDLE; m_cnt = 0;
          end
          M_PRESSED: if (n == 0) begin
            m_cnt = 1;
            m_st = (m_cnt >= DEB_FRAMES) ? M_IDLE : M_REL;
          end
          default: if (n == 0) begin
            m_cnt++;
            if (m_cnt >= DEB_FRAMES) m_st = M_IDLE;
          end else m_st = M_PRESSED;
        endcase
        seen.delete();
      end
    end
    m_evt = new_evt;
    cyc++;
    e_cols = 3'b111 & ~(3'b001 << ((cyc / SCAN_DIV) % 3));
  endtask

  task automatic compare();
    check("cols_n", 16'(cols_n), 16'(e_cols));
    check("keypad", 16'(keypad), 16'(e_keypad));
    check("startn", 16'(startn), 16'(e_startn));
    check("clearn", 16'(clearn), 16'(e_clearn));
    check("key_valid", 16'(key_valid), 16'(e_valid));
  endtask

  task automatic tick();
    @(negedge clock);
    if (resetn) model_step();
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_reset();
    check("rst_keypad", 16'(keypad), 16'd0);
    check("rst_valid", 16'(key_valid), 16'd0);
    compare();
    @(negedge clock);
    compare();
    resetn = 1'b1;
  endtask

  function automatic logic [11:0] key_bit(input int k);
    return 12'(1) << k;
  endfunction

  initial begin
    int  lat;
    bit  flag_a, flag_b, flag_c;
    int  k1, k2, kind;
    resetn  = 1'b0;
    pressed = '0;
    model_reset();

    // 1: reset and idle scanning
    do_reset();
    ticks(20);

    // 2: hold '3', measure assert and release latency
    pressed = key_bit(2);
    lat = 0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (lat == 0 && key_valid) lat = i;
    end
    check("lat_press_3", 16'(lat >= 1 && lat <= 10), 16'd1);
    check("hold_3", 16'(keypad), ONESHOT ? 16'd0 : 16'b0000001000);
    pressed = '0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (lat == 0 && !key_valid) lat = i;
    end
    check("lat_release_3", 16'(lat >= 1 && lat <= 10), 16'd1);
    ticks(6);

    // 3: bounce on '5', aligned so the closures never span two captured frames
    for (int i = 0; i < 3 && (cyc % 3) != 1; i++) tick();
    flag_a = 1'b0;
    for (int i = 0; i < 18; i++) begin
      pressed = (i < 2 || (i >= 4 && i < 6)) ? key_bit(4) : '0;
      tick();
      if (key_valid || keypad != 0) flag_a = 1'b1;
    end
    check("bounce_5_quiet", 16'(flag_a), 16'd0);

    // 4: '1' and '9' together, then '9' alone
    pressed = key_bit(0) | key_bit(8);
    flag_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (key_valid || keypad != 0) flag_a = 1'b1;
    end
    check("two_key_quiet", 16'(flag_a), 16'd0);
    pressed = key_bit(8);
    flag_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (keypad == 10'b1000000000) flag_b = 1'b1;
    end
    check("nine_seen", 16'(flag_b), 16'd1);
    check("nine_hold", 16'(keypad), ONESHOT ? 16'd0 : 16'b1000000000);
    pressed = '0;
    ticks(12);

    // 5: '#' then '*'
    flag_a = 1'b0; flag_b = 1'b0; flag_c = 1'b0;
    pressed = key_bit(11);
    for (int i = 0; i < 11; i++) begin
      tick();
      if (!startn) flag_a = 1'b1;
      if (!clearn || keypad != 0) flag_c = 1'b1;
    end
    pressed = '0;
    ticks(12);
    pressed = key_bit(9);
    for (int i = 0; i < 11; i++) begin
      tick();
      if (!clearn) flag_b = 1'b1;
      if (!startn || keypad != 0) flag_c = 1'b1;
    end
    pressed = '0;
    ticks(12);
    check("hash_startn", 16'(flag_a), 16'd1);
    check("star_clearn", 16'(flag_b), 16'd1);
    check("strobe_exclusive", 16'(flag_c), 16'd0);

    // 6: hold '7', reset mid-press, re-detect
    pressed = key_bit(6);
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (keypad[7]) lat = i;
    end
    check("seven_first", 16'(lat >= 1 && lat <= 10), 16'd1);
    ticks(3);
    do_reset();
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (lat == 0 && keypad[7]) lat = i;
    end
    check("seven_redetect", 16'(lat >= 1 && lat <= 10), 16'd1);
    pressed = '0;
    ticks(12);

    // Random key traffic
    for (int s = 0; s < 40; s++) begin
      kind = int'($urandom_range(0, 3));
      k1 = int'($urandom_range(0, 11));
      k2 = int'($urandom_range(0, 11));
      case (kind)
        0:       pressed = '0;
        3:       pressed = key_bit(k1) | key_bit(k2);
        default: pressed = key_bit(k1);
      endcase
      ticks(int'($urandom_range(1, 14)));
    end
    pressed = '0;
    ticks(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
